imem_loader: RTL and testbench

- Writer side of the instruction-memory read path used by the single-cycle core.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through a write port at sequential addresses 0..N-1.
- Holds the processor (core_hold) until the whole program is loaded, then releases it.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_byte_assembler.sv | 89 ++++++++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader state encoding and the default memory geometry.
// The optional end-of-program checksum is enabled by the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W    = 6;
    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_DATA_W    = 32;
    localparam int BYTES_PER_WORD = IMEM_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream into big-endian words (first byte lands in the top byte).
// Latency: word/word_valid are combinational with the byte that completes the word.
// Backpressure: none internally; the caller only asserts accept when it can take the byte.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               restart assembly (drops any partial word and the running XOR)
//   accept, byte_in   one byte is taken on a clock edge when accept=1
//   word, word_valid  assembled word including this cycle's byte; valid on the last byte
//   xor_sum           running XOR of every accepted byte (only with IMEM_LOADER_CHECKSUM_EN)
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    output logic [BPW*8-1:0]   word,
    output logic               word_valid
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]         xor_sum
`endif
);

    localparam int W     = BPW * 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end else if (accept) begin
            shift_d = {shift_q[W-9:0], byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = xor_q ^ byte_in;
`endif
            if (cnt_q == LAST_BYTE) begin
                cnt_d      = '0;
                word_valid = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Expose the post-shift value so the completed word can be registered
    // on the same edge that takes its last byte.
    assign word = shift_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign xor_sum = xor_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory and holds the core until done.
// Latency: last byte of a word taken at edge N -> mem_we high for the cycle after N.
// Backpressure: in_ready is low outside RECV/CHECK (including every WRITE cycle); bytes wait.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, word_count         begin a load of word_count words (IDLE/DONE only)
//   in_valid, in_byte, in_ready  byte stream handshake
//   mem_we, mem_addr, mem_wdata  instruction memory write port
//   core_hold, busy, done, error status (all registered)
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              core_hold_q, core_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              can_start;
    logic              wc_valid;
    logic              start_ok;
    logic              asm_accept;
    logic [DATA_W-1:0] asm_word;
    logic              asm_word_vld;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        asm_xor;
`endif

    assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wc_valid   = (word_count != '0) && (word_count <= DEPTH_CNT);
    assign start_ok   = start && can_start && wc_valid;
    // Program bytes only; the checksum byte in CHECK must not enter the assembler.
    assign asm_accept = in_valid && in_ready_q && (state_q == ST_RECV);

    imem_loader_byte_assembler #(
        .BPW        (DATA_W / 8)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .accept     (asm_accept),
        .byte_in    (in_byte),
        .word       (asm_word),
        .word_valid (asm_word_vld)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .xor_sum    (asm_xor)
`endif
    );

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        word_cnt_d  = word_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (wc_valid) begin
                        wc_d       = word_count;
                        word_cnt_d = '0;
                        mem_addr_d = '0;
                        error_d    = 1'b0;
                        state_d    = ST_RECV;
                    end else begin
                        // A rejected start also retracts a previous done.
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RECV: begin
                if (asm_word_vld) begin
                    mem_wdata_d = asm_word;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q + 1'b1 == wc_q) begin
                    // Last word: address stays on it, so it never wraps past DEPTH-1.
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    state_d    = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (in_valid && in_ready_q) begin
                    if (in_byte == asm_xor) begin
                        state_d = ST_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        mem_we_d    = (state_d == ST_WRITE);
        in_ready_d  = (state_d == ST_RECV) || (state_d == ST_CHECK);
        busy_d      = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
        done_d      = (state_d == ST_DONE);
        core_hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wc_q        <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            word_cnt_q  <= word_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
// Stimulus pushes expected (addr, word) writes; a negedge monitor pops and compares.
// Status and reset values are checked by the stimulus thread after each load.
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_total = 0;     // program bytes in the current load
    int          mon_cnt = 0;
    logic        prev_complete = 1'b0;
    logic [31:0] words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sees the registered outputs mid-cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            mon_cnt       = 0;
            prev_complete = 1'b0;
        end else begin
            if (mem_we || prev_complete)
                check("we_one_cycle_after_4th_byte", mem_we, prev_complete);
            if (mem_we) begin
                check("in_ready_low_in_write", in_ready, 1'b0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
            end
            prev_complete = 1'b0;
            if (start && !busy) begin
                mon_cnt = 0;
            end else if (in_valid && in_ready && mon_cnt < exp_total) begin
                mon_cnt++;
                prev_complete = (mon_cnt % 4 == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; word_count = '0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_core_hold", core_hold, 1'b1);
    endtask

    task automatic pulse_start(input int wc);
        word_count = 7'(wc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: toggle each cycle, 2: random gaps.
    // poke_at >= 0 pulses start (with a junk count) while that byte is offered.
    task automatic send_bytes(input logic [7:0] b[$], input int mode, input int poke_at);
        int   idx = 0;
        int   budget = 0;
        logic acc;
        logic poked = 1'b0;
        while (idx < b.size()) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ~in_valid;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_byte = in_valid ? b[idx] : 8'($urandom);
            if (idx == poke_at && !poked) begin
                start = 1'b1;
                word_count = 7'($urandom_range(0, 100));
                poked = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            start = 1'b0;
            if (acc) idx++;
            budget++;
            if (budget > 4 * b.size() + 200) begin
                checks++;
                errors++;
                $display("FAIL byte_stall: %0d of %0d bytes accepted", idx, b.size());
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL load_end_timeout: done=%0b error=%0b", done, error);
        end
    endtask

    // Reference: word k goes to address k; bytes are sent MSB first.
    task automatic run_load(input int wc, input int mode, input int poke_at, input logic bad_sum);
        logic [7:0] b[$];
        logic [7:0] x = 8'h00;
        logic [7:0] by;
        logic       exp_ok = 1'b1;
        exp_total = 4 * wc;
        pulse_start(wc);
        for (int k = 0; k < wc; k++) begin
            exp_q.push_back('{addr: k, data: words[k]});
            for (int j = 0; j < 4; j++) begin
                by = words[k][31 - 8 * j -: 8];
                b.push_back(by);
                x ^= by;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(bad_sum ? (x ^ 8'h01) : x);
        exp_ok = !bad_sum;
`else
        exp_ok = exp_ok & !bad_sum;
`endif
        send_bytes(b, mode, poke_at);
        wait_end();
        check("end_done", done, exp_ok);
        check("end_error", error, !exp_ok);
        check("end_core_hold", core_hold, !exp_ok);
        check("end_busy", busy, 1'b0);
        check("end_in_ready", in_ready, 1'b0);
        if (exp_ok) check("end_mem_addr", mem_addr, wc - 1);
        check("all_writes_seen", exp_q.size(), 0);
    endtask

    task automatic bad_start(input int wc);
        exp_total = 0;
        pulse_start(wc);
        tick();
        check("bad_wc_error", error, 1'b1);
        check("bad_wc_core_hold", core_hold, 1'b1);
        check("bad_wc_busy", busy, 1'b0);
        check("bad_wc_done", done, 1'b0);
        check("bad_wc_in_ready", in_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial[$];
        int         wc;

        do_reset(2);
        check_reset_values();

        // Single word, back-to-back bytes.
        words.delete();
        words.push_back(32'h12345678);
        run_load(1, 0, -1, 1'b0);

        // Full memory: word k = k, address must stop at DEPTH-1.
        words.delete();
        for (int k = 0; k < DEPTH; k++) words.push_back(32'(k));
        run_load(DEPTH, 0, -1, 1'b0);

        // Toggling in_valid.
        words.delete();
        words.push_back(32'hCAFE_F00D);
        words.push_back(32'h0BAD_BEEF);
        run_load(2, 1, -1, 1'b0);

        // Out-of-range word counts from IDLE.
        do_reset(1);
        bad_start(0);
        bad_start(DEPTH + 1);

        // Abort mid-word with reset, then reload.
        do_reset(1);
        exp_total = 4;
        pulse_start(1);
        partial.push_back(8'hAA);
        partial.push_back(8'hBB);
        send_bytes(partial, 0, -1);
        do_reset(1);
        check_reset_values();
        words.delete();
        words.push_back(32'h01020304);
        run_load(1, 0, -1, 1'b0);

        // Randomized loads, restarting from DONE; one pokes start mid-load.
        for (int r = 0; r < 6; r++) begin
            wc = $urandom_range(2, 8);
            words.delete();
            for (int k = 0; k < wc; k++) words.push_back($urandom);
            run_load(wc, $urandom_range(0, 2), (r == 2) ? 5 : -1, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words.delete();
        words.push_back(32'h12345678);
        run_load(1, 0, -1, 1'b0);
        run_load(1, 0, -1, 1'b1);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
